// File: rtl/axi_lite_master_seq_pkg.sv
// Shared types and AXI response codes for the AXI4-Lite command sequencer.
package axi_lite_master_seq_pkg;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RSP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_master_seq.sv
// AXI4-Lite initiator: one command in, one single-beat read or write out, one response back.
// A sticky monitor flags any channel that waits too long for its handshake.
module axi_lite_master_seq
  import axi_lite_master_seq_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]                    cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          timeout_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  state_t                          state_q, state_d;
  logic                            cmd_ready_q, cmd_ready_d;
  logic                            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                            arvalid_q, arvalid_d, rready_q, rready_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [3:0]                      wstrb_q, wstrb_d;
  logic                            rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [1:0]                      rsp_resp_q, rsp_resp_d;
  logic                            timeout_q, timeout_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic                            busy;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_ready_q && cmd_valid) begin
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            state_d   = WRITE;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = READ;
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      WRITE: begin
        // AW and W retire independently; each VALID stays up until its own handshake.
        awvalid_d = awvalid_q & ~M_AXI_AWREADY;
        wvalid_d  = wvalid_q & ~M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end
      end
      WRESP: begin
        if (M_AXI_BVALID) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = M_AXI_BRESP;
        end
      end
      READ: begin
        if (M_AXI_ARREADY) begin
          state_d   = RDATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RDATA: begin
        if (M_AXI_RVALID) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter restarts on every state change and saturates at the limit.
    busy = (state_q == WRITE) || (state_q == WRESP) || (state_q == READ) || (state_q == RDATA);
    if ((TIMEOUT_CYCLES == 0) || !busy || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_d == CntMax) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign timeout_err   = timeout_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
